// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state, access owner
// and the saturating starvation-count step.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_t;

    function automatic logic [3:0] starve_next(input logic [3:0] cnt, input logic [3:0] lim);
        if (cnt >= lim) begin
            return lim;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ready;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output core_ready, core_rdata, core_stall,
        output dbg_ready, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  core_ready, core_rdata, core_stall,
        input  dbg_ready, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: one
// fixed-latency access at a time, core preferred, dbg protected from starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int WAIT_CYC   = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYC - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    arb_state_t        state_r;
    arb_state_t        state_s;
    arb_owner_t        owner_r;
    logic              we_r;
    logic [2:0]        wait_cnt_r;
    logic [3:0]        starve_cnt_r;
    logic              grant_s;
    logic              grant_dbg_s;
    logic              last_s;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic              busy_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              core_ready_r;
    logic              dbg_ready_r;
    logic [DATA_W-1:0] core_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;

    // Next-state logic with grant decision and last-access-cycle detect.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_dbg_s = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.core_req || bus.dbg_req) begin
                    grant_s     = 1'b1;
                    // dbg_req guard keeps a saturated count from granting an absent dbg
                    grant_dbg_s = bus.dbg_req && (!bus.core_req || (starve_cnt_r == STARVE_MAX));
                    state_s     = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    last_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Wait and starvation counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r   <= 3'd0;
            starve_cnt_r <= 4'd0;
        end else begin
            if (state_r == ACCESS) begin
                wait_cnt_r <= last_s ? 3'd0 : (wait_cnt_r + 3'd1);
            end
            if (grant_s && grant_dbg_s) begin
                starve_cnt_r <= 4'd0;
            end else if (grant_s && bus.dbg_req) begin
                starve_cnt_r <= starve_next(starve_cnt_r, STARVE_MAX);
            end
        end
    end

    // Transaction latch and memory port; address/data hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= OWN_CORE;
            we_r        <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (grant_s) begin
            owner_r     <= grant_dbg_s ? OWN_DBG : OWN_CORE;
            we_r        <= grant_dbg_s ? bus.dbg_we : bus.core_we;
            mem_rd_r    <= grant_dbg_s ? !bus.dbg_we : !bus.core_we;
            mem_wr_r    <= grant_dbg_s ? bus.dbg_we : bus.core_we;
            mem_addr_r  <= grant_dbg_s ? bus.dbg_addr : bus.core_addr;
            mem_wdata_r <= grant_dbg_s ? bus.dbg_wdata : bus.core_wdata;
        end else if (last_s) begin
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
        end
    end

    // Completion pulses and per-requester read data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready_r <= 1'b0;
            dbg_ready_r  <= 1'b0;
            core_rdata_r <= '0;
            dbg_rdata_r  <= '0;
        end else begin
            core_ready_r <= last_s && (owner_r == OWN_CORE);
            dbg_ready_r  <= last_s && (owner_r == OWN_DBG);
            if (last_s && !we_r && (owner_r == OWN_DBG)) begin
                dbg_rdata_r <= bus.mem_rdata;
            end
            if (last_s && !we_r && (owner_r == OWN_CORE)) begin
                core_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.core_ready = core_ready_r;
    assign bus.core_rdata = core_rdata_r;
    assign bus.dbg_ready  = dbg_ready_r;
    assign bus.dbg_rdata  = dbg_rdata_r;
    assign bus.busy       = busy_r;
    assign bus.core_stall = bus.core_req && !core_ready_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int WC  = 2;
    localparam int SL  = 4;
    localparam int WC3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(WC), .STARVE_LIM(SL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(WC3), .STARVE_LIM(SL)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // Power-up memory contents; address 0x010 holds 0xDEADBEEF.
    function automatic logic [31:0] init_val(input logic [8:0] a);
        return 32'hDEADBEEF + (({23'd0, a}) - 32'h0000_0010) * 32'h0100_0193;
    endfunction

    logic [31:0] mem [0:511];
    bit          mem_written [0:511];
    logic [31:0] ref_mem [0:511];

    // Behavioural single-port memory behind the main arbiter.
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_addr]         <= bus.mem_wdata;
            mem_written[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_rdata  = mem_written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    assign bus3.mem_rdata = init_val(bus3.mem_addr);

    task automatic idle_inputs();
        bus.core_req  = 1'b0; bus.core_we  = 1'b0; bus.core_addr  = 9'd0; bus.core_wdata  = 32'd0;
        bus.dbg_req   = 1'b0; bus.dbg_we   = 1'b0; bus.dbg_addr   = 9'd0; bus.dbg_wdata   = 32'd0;
        bus3.core_req = 1'b0; bus3.core_we = 1'b0; bus3.core_addr = 9'd0; bus3.core_wdata = 32'd0;
        bus3.dbg_req  = 1'b0; bus3.dbg_we  = 1'b0; bus3.dbg_addr  = 9'd0; bus3.dbg_wdata  = 32'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.core_req = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", bus.mem_rd, bus.mem_wr); end
        n_tests++; if (bus.mem_addr !== 9'd0 || bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
        n_tests++; if (bus.core_ready !== 1'b0 || bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: core=%b dbg=%b want 0 0", bus.core_ready, bus.dbg_ready); end
        n_tests++; if (bus.core_rdata !== 32'd0 || bus.dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: core=%h dbg=%h want 0 0", bus.core_rdata, bus.dbg_rdata); end
        n_tests++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_hi: got %b want 1", bus.core_stall); end
        bus.core_req = 1'b0;
        #1;
        n_tests++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo: got %b want 0", bus.core_stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_core_read();
        logic exp_acc;
        apply_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h010;
        #1;
        n_tests++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL core_read_stall_c0: got %b want 1", bus.core_stall); end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            exp_acc = (c <= 2);
            n_tests++; if (bus.mem_rd !== exp_acc || bus.core_stall !== exp_acc) begin n_fail++; $display("FAIL core_read_strobe c=%0d: rd=%b stall=%b want %b", c, bus.mem_rd, bus.core_stall, exp_acc); end
            if (c <= 2) begin
                n_tests++; if (bus.mem_addr !== 9'h010 || bus.core_ready !== 1'b0) begin n_fail++; $display("FAIL core_read_access c=%0d: addr=%h ready=%b want 010 0", c, bus.mem_addr, bus.core_ready); end
            end else begin
                n_tests++; if (bus.core_ready !== 1'b1 || bus.core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_read_resp: ready=%b rdata=%h want 1 deadbeef", bus.core_ready, bus.core_rdata); end
            end
        end
        @(negedge clk);
        bus.core_req = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (bus.core_ready !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL core_read_after: ready=%b busy=%b want 0 0", bus.core_ready, bus.busy); end
    endtask

    task automatic test_dbg_write();
        apply_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h020;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.dbg_ready !== 1'b1 || bus.dbg_rdata !== init_val(9'h020)) begin n_fail++; $display("FAIL dbg_pre_read: ready=%b rdata=%h want 1 %h", bus.dbg_ready, bus.dbg_rdata, init_val(9'h020)); end
        @(negedge clk);
        bus.dbg_we = 1'b1; bus.dbg_addr = 9'h1FF; bus.dbg_wdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                n_tests++; if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL dbg_write_idle: wr=%b busy=%b ready=%b want 0 0 0", bus.mem_wr, bus.busy, bus.dbg_ready); end
            end else if (c <= 3) begin
                n_tests++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 9'h1FF || bus.mem_wdata !== 32'h12345678 || bus.dbg_ready !== 1'b0) begin
                    n_fail++; $display("FAIL dbg_write_access c=%0d: wr=%b rd=%b addr=%h wdata=%h ready=%b want 1 0 1ff 12345678 0", c, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata, bus.dbg_ready);
                end
            end else begin
                n_tests++; if (bus.dbg_ready !== 1'b1 || bus.mem_wr !== 1'b0 || bus.dbg_rdata !== init_val(9'h020) || bus.core_ready !== 1'b0) begin
                    n_fail++; $display("FAIL dbg_write_resp: ready=%b wr=%b rdata=%h core_ready=%b want 1 0 %h 0", bus.dbg_ready, bus.mem_wr, bus.dbg_rdata, bus.core_ready, init_val(9'h020));
                end
            end
        end
        @(negedge clk);
        bus.dbg_req = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL dbg_write_single_pulse: got %b want 0", bus.dbg_ready); end
    endtask

    task automatic test_starvation();
        logic exp_dbg;
        apply_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h030;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b0; bus.dbg_addr  = 9'h040;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c % 4 == 3) begin
                exp_dbg = ((c / 4) % 5 == 4);
                n_tests++; if (bus.dbg_ready !== exp_dbg || bus.core_ready !== !exp_dbg) begin n_fail++; $display("FAIL starve_grant t=%0d: core_ready=%b dbg_ready=%b want %b %b", c / 4, bus.core_ready, bus.dbg_ready, !exp_dbg, exp_dbg); end
                n_tests++; if ((exp_dbg ? bus.dbg_rdata : bus.core_rdata) !== (exp_dbg ? init_val(9'h040) : init_val(9'h030))) begin n_fail++; $display("FAIL starve_rdata t=%0d: core=%h dbg=%h", c / 4, bus.core_rdata, bus.dbg_rdata); end
            end else begin
                n_tests++; if (bus.core_ready !== 1'b0 || bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL starve_quiet c=%0d: core_ready=%b dbg_ready=%b want 0 0", c, bus.core_ready, bus.dbg_ready); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h050;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b0; bus.dbg_addr  = 9'h060;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            n_tests++; if (bus.dbg_ready !== (c == 7)) begin n_fail++; $display("FAIL simul_dbg_ready c=%0d: got %b want %b", c, bus.dbg_ready, (c == 7)); end
            if (c == 3) begin
                n_tests++; if (bus.core_ready !== 1'b1 || bus.core_rdata !== init_val(9'h050)) begin n_fail++; $display("FAIL simul_core_first: ready=%b rdata=%h want 1 %h", bus.core_ready, bus.core_rdata, init_val(9'h050)); end
                @(negedge clk);
                bus.core_req = 1'b0;
            end
            if (c == 5 || c == 6) begin
                n_tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h060) begin n_fail++; $display("FAIL simul_dbg_access c=%0d: rd=%b addr=%h want 1 060", c, bus.mem_rd, bus.mem_addr); end
            end
            if (c == 7) begin
                n_tests++; if (bus.dbg_rdata !== init_val(9'h060)) begin n_fail++; $display("FAIL simul_dbg_rdata: got %h want %h", bus.dbg_rdata, init_val(9'h060)); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        bus3.core_req = 1'b1; bus3.core_we = 1'b0; bus3.core_addr = 9'h070;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus3.mem_rd !== 1'b1 || bus3.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_before: rd=%b busy=%b want 1 1", bus3.mem_rd, bus3.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus3.mem_rd !== 1'b0 || bus3.busy !== 1'b0 || bus3.core_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: rd=%b busy=%b ready=%b want 0 0 0", bus3.mem_rd, bus3.busy, bus3.core_ready); end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            n_tests++; if (bus3.core_ready !== 1'b0 || bus3.mem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_held c=%0d: ready=%b rd=%b want 0 0", c, bus3.core_ready, bus3.mem_rd); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c <= 3) begin
                n_tests++; if (bus3.mem_rd !== 1'b1 || bus3.core_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_restart c=%0d: rd=%b ready=%b want 1 0", c, bus3.mem_rd, bus3.core_ready); end
            end else begin
                n_tests++; if (bus3.core_ready !== 1'b1 || bus3.core_rdata !== init_val(9'h070) || bus3.mem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_resp: ready=%b rdata=%h rd=%b want 1 %h 0", bus3.core_ready, bus3.core_rdata, bus3.mem_rd, init_val(9'h070)); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        apply_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h001;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            exp_rdy = (c == 3) || (c == 7);
            n_tests++; if (bus.core_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, bus.core_ready, exp_rdy); end
            if (c == 3) begin
                n_tests++; if (bus.core_rdata !== init_val(9'h001)) begin n_fail++; $display("FAIL b2b_rdata1: got %h want %h", bus.core_rdata, init_val(9'h001)); end
                @(negedge clk);
                bus.core_addr = 9'h002;
            end
            if (c == 7) begin
                n_tests++; if (bus.core_rdata !== init_val(9'h002)) begin n_fail++; $display("FAIL b2b_rdata2: got %h want %h", bus.core_rdata, init_val(9'h002)); end
                @(negedge clk);
                bus.core_req = 1'b0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int          busy_left;
        int          starve;
        bit          own_dbg;
        bit          m_we;
        logic [8:0]  m_addr;
        logic [31:0] m_wdata;
        logic [31:0] m_rd_val;
        logic [31:0] exp_core_rd;
        logic [31:0] exp_dbg_rd;
        bit          c_done;
        bit          d_done;
        bit          exp_cr;
        bit          exp_dr;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(9'(i));
        ref_mem[9'h1FF] = 32'h12345678;
        busy_left = 0; starve = 0; own_dbg = 1'b0; m_we = 1'b0;
        m_addr = 9'd0; m_wdata = 32'd0; m_rd_val = 32'd0;
        exp_core_rd = 32'd0; exp_dbg_rd = 32'd0;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            c_done = (busy_left == 1) && !own_dbg;
            d_done = (busy_left == 1) && own_dbg;
            if (c_done || !bus.core_req) begin
                bus.core_req = ($urandom_range(0, 99) < 60);
                bus.core_we = 1'($urandom_range(0, 1));
                bus.core_addr = 9'($urandom_range(0, 23));
                bus.core_wdata = $urandom;
            end
            if (d_done || !bus.dbg_req) begin
                bus.dbg_req = ($urandom_range(0, 99) < 50);
                bus.dbg_we = 1'($urandom_range(0, 1));
                bus.dbg_addr = 9'($urandom_range(0, 23));
                bus.dbg_wdata = $urandom;
            end
            @(posedge clk);
            // Reference: one access occupies WC access cycles plus one response cycle.
            if (busy_left == 0) begin
                if (bus.core_req || bus.dbg_req) begin
                    own_dbg = bus.dbg_req && (!bus.core_req || starve == SL);
                    if (own_dbg) starve = 0;
                    else if (bus.dbg_req && starve < SL) starve++;
                    m_we    = own_dbg ? bus.dbg_we : bus.core_we;
                    m_addr  = own_dbg ? bus.dbg_addr : bus.core_addr;
                    m_wdata = own_dbg ? bus.dbg_wdata : bus.core_wdata;
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else m_rd_val = ref_mem[m_addr];
                    busy_left = WC + 1;
                end
            end else begin
                busy_left--;
            end
            if (busy_left == 1 && !m_we) begin
                if (own_dbg) exp_dbg_rd = m_rd_val;
                else exp_core_rd = m_rd_val;
            end
            exp_cr = (busy_left == 1) && !own_dbg;
            exp_dr = (busy_left == 1) && own_dbg;
            #1;
            n_tests++; if (bus.busy !== (busy_left != 0) || bus.mem_rd !== (busy_left >= 2 && !m_we) || bus.mem_wr !== (busy_left >= 2 && m_we)) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d: busy=%b rd=%b wr=%b want %b %b %b", cyc, bus.busy, bus.mem_rd, bus.mem_wr, (busy_left != 0), (busy_left >= 2 && !m_we), (busy_left >= 2 && m_we));
            end
            n_tests++; if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) begin
                n_fail++; $display("FAIL rand_membus cyc=%0d: addr=%h wdata=%h want %h %h", cyc, bus.mem_addr, bus.mem_wdata, m_addr, m_wdata);
            end
            n_tests++; if (bus.core_ready !== exp_cr || bus.dbg_ready !== exp_dr || bus.core_stall !== (bus.core_req && !exp_cr)) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d: core=%b dbg=%b stall=%b want %b %b %b", cyc, bus.core_ready, bus.dbg_ready, bus.core_stall, exp_cr, exp_dr, (bus.core_req && !exp_cr));
            end
            n_tests++; if (bus.core_rdata !== exp_core_rd || bus.dbg_rdata !== exp_dbg_rd) begin
                n_fail++; $display("FAIL rand_rdata cyc=%0d: core=%h dbg=%h want %h %h", cyc, bus.core_rdata, bus.dbg_rdata, exp_core_rd, exp_dbg_rd);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_core_read();
        test_dbg_write();
        test_starvation();
        test_simultaneous();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
